// File: rtl/dmem_ctrl.sv
// Data-memory initiator: turns one CPU load/store at a time into byte-lane
// accesses on four byteram lanes, splitting lane-crossing accesses into two
// word beats and returning rotated, zero- or sign-extended load data.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only when idle)
//   req_we/size/signed/addr/wdata request payload
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse with load data
//   mem_addr/we/be/wdata         shared word address, write enable, lane enables
//   mem_rdata                    concatenated lane read data (combinational)
module dmem_ctrl #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned WW = AW - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Lane mask over two consecutive words: bits [3:0] first word, [6:4] second.
  function automatic logic [6:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [6:0] base;
    case (size)
      2'b00:   base = 7'b000_0001;
      2'b01:   base = 7'b000_0011;
      default: base = 7'b000_1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [DW-1:0] rotl8(input logic [DW-1:0] w, input logic [1:0] off);
    logic [5:0] sh;
    sh = {1'b0, off, 3'b000};
    return (w << sh) | (w >> (6'd32 - sh));
  endfunction

  function automatic logic [DW-1:0] rotr8(input logic [DW-1:0] w, input logic [1:0] off);
    logic [5:0] sh;
    sh = {1'b0, off, 3'b000};
    return (w >> sh) | (w << (6'd32 - sh));
  endfunction

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] w, input logic [1:0] size,
                                           input logic sgn);
    case (size)
      2'b00:   return {{24{sgn & w[7]}}, w[7:0]};
      2'b01:   return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rbuf_q, rbuf_d;

  logic [6:0]    mask;
  logic [DW-1:0] rmerge;
  logic [WW-1:0] word_nxt;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    rbuf_d      = rbuf_q;

    // In IDLE the mask is for the incoming request, otherwise for the captured one.
    mask = (state_q == IDLE) ? lane_mask(req_size, req_addr[1:0])
                             : lane_mask(size_q, addr_q[1:0]);

    // Enabled lanes take fresh read data; the two beats never enable the same lane.
    for (int i = 0; i < 4; i++) begin
      rmerge[8*i +: 8] = mem_be_q[i] ? mem_rdata[8*i +: 8] : rbuf_q[8*i +: 8];
    end

    word_nxt = addr_q[AW-1:2] + WW'(1);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          rbuf_d   = '0;
          if (req_size == 2'b11) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_addr_d  = {req_addr[AW-1:2], 2'b00};
            mem_be_d    = mask[3:0];
            mem_we_d    = req_we;
            mem_wdata_d = rotl8(req_wdata, req_addr[1:0]);
          end
        end
      end
      BEAT0, BEAT1: begin
        if (!we_q) rbuf_d = rmerge;
        if (state_q == BEAT0 && mask[6:4] != 3'b000) begin
          state_d    = BEAT1;
          mem_addr_d = {word_nxt, 2'b00};
          mem_be_d   = {1'b0, mask[6:4]};
        end else begin
          state_d     = RESP;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : extend(rotr8(rmerge, addr_q[1:0]), size_q, signed_q);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      rbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      rbuf_q      <= rbuf_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
